iter_divider: RTL and testbench

- Multi-cycle restoring shift-subtract divider for the pipeline's DIV/DIVU instructions.
- Computes one quotient bit per cycle.
- Sits beside the combinational ALU/shifter in EX. The hazard unit stalls the pipeline on busy and captures results on done.
- Supports signed and unsigned operands with a start/busy/done handshake.

---
 rtl/iter_divider_pkg.sv | 19 +
 rtl/iter_divider_div_step.sv | 27 ++
 rtl/iter_divider.sv | 109 ++++++++++
 tb/tb_iter_divider.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/iter_divider_pkg.sv
// Shared constants for the iterative DIV/DIVU unit: FSM encoding, default
// width and the iteration-counter sizing.
package iter_divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring shift-subtract iteration: shifts {rem, quo} left by one and
// keeps the subtraction only when it does not go negative.
module iter_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] b_mag_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_ok;

  assign shifted = {rem_i, quo_i[WIDTH-1]};
  // Extra guard bit so the borrow is a clean sign even for a full-range shifted value.
  assign trial   = {1'b0, shifted} - {2'b00, b_mag_i};

  assign rem_o = trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH+1]};

  // Kept remainder is always below b_mag, so the top bits are provably zero.
  assign unused_ok = ^{shifted[WIDTH], trial[WIDTH]};

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign fix-up in a final cycle, start/busy/done handshake toward the hazard unit.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_q;
  logic [WIDTH-1:0] rem_q, quo_q, bmag_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [CW-1:0]    cnt_q;
  logic             signed_q, neg_quo_q, neg_rem_q, zero_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Most negative value negates to itself, which is its correct unsigned magnitude.
  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? ('0 - dividend) : dividend;
  assign b_mag = b_neg ? ('0 - divisor)  : divisor;

  iter_divider_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i   (rem_q),
    .quo_i   (quo_q),
    .b_mag_i (bmag_q),
    .rem_o   (rem_d),
    .quo_o   (quo_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      bmag_q      <= '0;
      cnt_q       <= '0;
      signed_q    <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            signed_q  <= is_signed;
            neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_q <= dividend[WIDTH-1];
            zero_q    <= (divisor == '0);
            rem_q     <= '0;
            quo_q     <= a_mag;
            bmag_q    <= b_mag;
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          // With a zero divisor the loop leaves |a| in rem, so the sign fix
          // alone restores the original dividend as the remainder.
          quotient_q  <= zero_q ? '1 :
                         (signed_q && neg_quo_q) ? ('0 - quo_q) : quo_q;
          remainder_q <= (signed_q && neg_rem_q) ? ('0 - rem_q) : rem_q;
          dbz_q       <= zero_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: hand-computed results, latency, handshake,
// divide-by-zero, signed overflow, ignored restarts and mid-operation reset.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;

  iter_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Holds start across one rising edge; t0 marks that accepting edge.
  task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input bit align);
    if (align) @(negedge clk);
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_done(output int lat, output logic busy_ok);
    bit got;
    got     = 1'b0;
    lat     = -1;
    busy_ok = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] eq, input logic [31:0] er,
                              input logic ez);
    int   lat;
    logic bok;
    wait_done(lat, bok);
    chk({tag, " latency"}, 32'(lat), 32'd33);
    chk({tag, " busy"}, 32'(bok), 32'd1);
    chk({tag, " quo"}, quotient, eq);
    chk({tag, " rem"}, remainder, er);
    chk({tag, " dbz"}, 32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst quo", quotient, 32'd0);
    chk("rst rem", remainder, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    start_div(32'd100, 32'd7, 1'b0, 1'b1);
    chk("u100/7 busy1", 32'(busy), 32'd1);
    check_result("u100/7", 32'd14, 32'd2, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("hold quo", quotient, 32'd14);
    chk("hold done", 32'(done), 32'd0);

    start_div(-32'sd7, 32'd2, 1'b1, 1'b1);
    check_result("s-7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    start_div(32'd7, -32'sd2, 1'b1, 1'b1);
    check_result("s7/-2", 32'hFFFF_FFFD, 32'd1, 1'b0);
    start_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check_result("s ovf", 32'h8000_0000, 32'd0, 1'b0);
    start_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    check_result("umax/1", 32'hFFFF_FFFF, 32'd0, 1'b0);
    start_div(32'h1234, 32'd0, 1'b0, 1'b1);
    check_result("u dz", 32'hFFFF_FFFF, 32'h1234, 1'b1);
    start_div(-32'sd5, 32'd0, 1'b1, 1'b1);
    check_result("s dz", 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);

    // Restart attempt while busy must be ignored.
    start_div(32'd50, 32'd3, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd9; is_signed = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'd5;
    check_result("50/3", 32'd16, 32'd2, 1'b0);
    // Back-to-back start issued in the done cycle.
    start_div(32'd9, 32'd9, 1'b0, 1'b0);
    check_result("b2b 9/9", 32'd1, 32'd0, 1'b0);

    // Prime non-zero flags so the reset clear is observable.
    start_div(32'd5, 32'd0, 1'b0, 1'b1);
    check_result("pre dz", 32'hFFFF_FFFF, 32'd5, 1'b1);
    start_div(32'd1000, 32'd7, 1'b0, 1'b1);
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst quo", quotient, 32'd0);
    chk("mid rst rem", remainder, 32'd0);
    chk("mid rst dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("no done after rst", 32'(seen), 32'd0);
    start_div(32'd20, 32'd6, 1'b0, 1'b1);
    check_result("20/6", 32'd3, 32'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
